// File: rtl/fx_pkg.sv
// Shared definitions for the audio effects: Q15 gain constants, mode encoding,
// sequencer states and the accumulator width rule used before saturation.
package fx_pkg;

    localparam int Q15_W    = 16;
    localparam int Q15_FRAC = 15;

    localparam logic signed [Q15_W-1:0] Q15_HALF     = 16'sh4000;  //  0.5
    localparam logic signed [Q15_W-1:0] Q15_0P6      = 16'sh4CCC;  //  0.6 (19660)
    localparam logic signed [Q15_W-1:0] Q15_NEG_HALF = 16'shC000;  // -0.5

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'b00,
        MODE_CHORUS     = 2'b01,
        MODE_FLANGER    = 2'b10,
        MODE_CHORUS_ALT = 2'b11
    } fx_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_MAC,
        ST_WR
    } fx_state_e;

    // Sum of two DATA_W x Q15 products needs one extra bit of headroom.
    function automatic int sat_acc_w(input int data_w);
        return data_w + Q15_W + 1;
    endfunction

endpackage

// File: rtl/fx_delay_ram.sv
// Simple dual-port delay line: one write port, one synchronous read port,
// shaped so synthesis maps it onto a block RAM.
module fx_delay_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // NOTE: no reset on the array or read register; a reset would stop block RAM
    // inference, and the owner masks words that were never written.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/mod_delay_fx.sv
// Modulated delay effect (bypass / chorus / flanger): one sample per four cycles
// through an IDLE -> RD -> MAC -> WR sequence around a delay RAM.
module mod_delay_fx
    import fx_pkg::*;
#(
    parameter int                      DATA_W     = 16,
    parameter int                      DEPTH_LOG2 = 10,
    parameter int                      MOD_W      = 9,
    parameter int                      BASE_DELAY = 200,
    parameter logic signed [Q15_W-1:0] GAIN_DRY   = Q15_HALF,
    parameter logic signed [Q15_W-1:0] GAIN_WET   = Q15_0P6,
    parameter logic signed [Q15_W-1:0] GAIN_FB    = Q15_NEG_HALF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] audio_in,
    input  logic        [MOD_W-1:0]  sin_mod,
    input  logic        [1:0]        mode,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] audio_out
);

    localparam int ACC_W = sat_acc_w(DATA_W);
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0] FILL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0] BASE_D   = CNT_W'(BASE_DELAY);

    localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  MAX_A = {{(ACC_W-DATA_W){1'b0}}, MAX_D};
    localparam logic signed [ACC_W-1:0]  MIN_A = {{(ACC_W-DATA_W){1'b1}}, MIN_D};

    localparam logic signed [ACC_W-1:0] G_DRY = {{(ACC_W-Q15_W){GAIN_DRY[Q15_W-1]}}, GAIN_DRY};
    localparam logic signed [ACC_W-1:0] G_WET = {{(ACC_W-Q15_W){GAIN_WET[Q15_W-1]}}, GAIN_WET};
    localparam logic signed [ACC_W-1:0] G_FB  = {{(ACC_W-Q15_W){GAIN_FB[Q15_W-1]}},  GAIN_FB};

    if (BASE_DELAY < 1 || BASE_DELAY + (1 << MOD_W) - 1 >= (1 << DEPTH_LOG2)) begin : g_bad_delay
        $error("mod_delay_fx: BASE_DELAY + sin_mod range does not fit the delay memory");
    end

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > MAX_A)      return MAX_D;
        else if (v < MIN_A) return MIN_D;
        else                return v[DATA_W-1:0];
    endfunction

    fx_state_e                state_q, state_d;
    fx_mode_e                 mode_q;
    logic signed [DATA_W-1:0] x_q, wet_q, audio_out_q;
    logic        [MOD_W-1:0]  mod_q;
    logic [DEPTH_LOG2-1:0]    wr_ptr_q, rd_addr;
    logic [CNT_W-1:0]         fill_cnt_q, delay_d;
    logic                     out_valid_q, accept, rd_en, wr_en;
    logic        [DATA_W-1:0] rd_data;
    logic signed [ACC_W-1:0]  x_ext, wet_ext, mix_acc, fb_acc;
    logic signed [DATA_W-1:0] y_d, wr_data_d;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD;
            ST_RD:   state_d = ST_MAC;
            ST_MAC:  state_d = ST_WR;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        in_ready = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_RD:   rd_en    = 1'b1;
            ST_WR:   wr_en    = 1'b1;
            default: ;
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign delay_d = BASE_D + CNT_W'(mod_q);
    assign rd_addr = wr_ptr_q - delay_d[DEPTH_LOG2-1:0];

    always_comb begin
        x_ext     = {{(ACC_W-DATA_W){x_q[DATA_W-1]}}, x_q};
        wet_ext   = {{(ACC_W-DATA_W){wet_q[DATA_W-1]}}, wet_q};
        mix_acc   = (x_ext * G_DRY + wet_ext * G_WET) >>> Q15_FRAC;
        fb_acc    = x_ext + ((wet_ext * G_FB) >>> Q15_FRAC);
        y_d       = (mode_q == MODE_BYPASS)  ? x_q : sat(mix_acc);
        wr_data_d = (mode_q == MODE_FLANGER) ? sat(fb_acc) : x_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            mod_q       <= '0;
            mode_q      <= MODE_BYPASS;
            wet_q       <= '0;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            audio_out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_q == ST_WR);
            if (accept) begin
                x_q    <= audio_in;
                mod_q  <= sin_mod;
                mode_q <= fx_mode_e'(mode);
            end
            // Words older than the number of samples written are stale or never written.
            if (state_q == ST_MAC) wet_q <= (fill_cnt_q < delay_d) ? '0 : rd_data;
            if (state_q == ST_WR) begin
                wr_ptr_q    <= wr_ptr_q + DEPTH_LOG2'(1);
                audio_out_q <= y_d;
                if (fill_cnt_q != FILL_MAX) fill_cnt_q <= fill_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign audio_out = audio_out_q;

    fx_delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_d),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

endmodule
